// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite memory slave with programmable wait states and ERROR responses
module ahb_slave_mem #(
  parameter int WAIT_STATES = 1,
  parameter int MEM_WORDS = 256
) (
  input  logic        hclk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [15:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);
  localparam int AW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic dp_q, dp_d;
  logic [AW+1:0] addr_q, addr_d;
  logic write_q, write_d;
  logic [1:0] size_q, size_d;
  logic [31:0] mem [MEM_WORDS];
  logic acc, err, done;
  logic [3:0] be;
  logic [AW-1:0] idx;
  logic unused_ok;
  assign unused_ok = ^{haddr[15:13], htrans[0]};
  assign hreadyout = (state_q == IDLE) || (state_q == ERR2);
  assign hresp = (state_q == ERR1) || (state_q == ERR2);
  assign acc = hsel && hready && htrans[1] && hreadyout;
  assign err = (hsize > 3'd2) || (hsize == 3'd1 && haddr[0]) || (hsize == 3'd2 && haddr[1:0] != 2'd0)
               || (int'(haddr[12:2]) >= MEM_WORDS);
  assign done = (state_q == IDLE) && dp_q;
  assign idx = addr_q[AW+1:2];
  assign be = size_q == 2'd0 ? 4'b0001 << addr_q[1:0] : size_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign hrdata = (done && !write_q) ? mem[idx] : 32'd0;
  // next-state: wait countdown, two-cycle error response, address-phase capture when ready
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dp_d = dp_q;
    addr_d = addr_q;
    write_d = write_q;
    size_d = size_q;
    if (state_q == WAIT) begin
      cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      state_d = (cnt_q == 4'd0) ? IDLE : WAIT;
    end else if (state_q == ERR1) begin
      state_d = ERR2;
    end else begin
      dp_d = acc && !err;
      state_d = !acc ? IDLE : err ? ERR1 : (WAIT_STATES > 0) ? WAIT : IDLE;
      cnt_d = (acc && !err && WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
      addr_d = acc ? haddr[AW+1:0] : addr_q;
      write_d = acc ? hwrite : write_q;
      size_d = acc ? hsize[1:0] : size_q;
    end
  end
  // control state registers; reset drops any pending data phase
  always_ff @(posedge hclk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      dp_q <= 1'b0;
      addr_q <= '0;
      write_q <= 1'b0;
      size_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dp_q <= dp_d;
      addr_q <= addr_d;
      write_q <= write_d;
      size_q <= size_d;
    end
  end
  // storage is never cleared; a write lands only on its completing cycle with that cycle's hwdata
  always_ff @(posedge hclk) begin
    if (!rst && done && write_q)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= hwdata[8*i +: 8];
  end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: table-driven pipelined bus master with scoreboard for two wait-state configurations
module tb_ahb_slave_mem;
  logic hclk = 0, rst = 1, hsel = 0, use0 = 0, hwrite = 0;
  logic [15:0] haddr = 0;
  logic [1:0] htrans = 0;
  logic [2:0] hsize = 0;
  logic [31:0] hwdata = 0;
  logic [31:0] rd0, rd1, rd;
  logic ro0, ro1, rs0, rs1, hready, rs, hsel0, hsel1;
  assign hsel0 = hsel && use0;
  assign hsel1 = hsel && !use0;
  assign hready = use0 ? ro0 : ro1;
  assign rs = use0 ? rs0 : rs1;
  assign rd = use0 ? rd0 : rd1;
  always #5 hclk = ~hclk;
  ahb_slave_mem #(.WAIT_STATES(1), .MEM_WORDS(256)) u_ws1 (
    .hclk(hclk), .rst(rst), .hsel(hsel1), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready(hready), .hrdata(rd1), .hreadyout(ro1), .hresp(rs1));
  ahb_slave_mem #(.WAIT_STATES(0), .MEM_WORDS(256)) u_ws0 (
    .hclk(hclk), .rst(rst), .hsel(hsel0), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready(hready), .hrdata(rd0), .hreadyout(ro0), .hresp(rs0));
  typedef struct {bit ws0; bit wr; logic [15:0] a; logic [2:0] sz; logic [31:0] wd; bit err; logic [31:0] rd;} vec_t;
  typedef struct {bit err; logic [31:0] rd; int cyc;} exp_t;
  exp_t sb[$];
  vec_t tv[$];
  int errors = 0, checks = 0;
  bit in_dp = 0, mid_bad = 0;
  int cyc = 0;
  exp_t e;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: idle-cycle checks, data-phase length and completion values against the scoreboard
  always @(negedge hclk) begin
    if (rst) in_dp = 0;
    else begin
      if (in_dp) begin
        cyc++;
        if (hready) begin
          in_dp = 0;
          if (sb.size() == 0) chk("unexpected completion", 1, 0);
          else begin
            e = sb.pop_front();
            chk("hresp", rs, e.err);
            chk("hrdata", rd, e.rd);
            chk("cycles", cyc, e.cyc);
            chk("stall cycles", mid_bad, 0);
          end
        end else mid_bad = mid_bad || rd !== 0 || (sb.size() > 0 && rs !== sb[0].err);
      end else begin
        chk("idle hreadyout", hready, 1);
        chk("idle hresp", rs, 0);
        chk("idle hrdata", rd, 0);
      end
      if (!in_dp && hsel && hready && htrans[1]) begin
        in_dp = 1;
        cyc = 0;
        mid_bad = 0;
      end
    end
  end
  task automatic issue(input vec_t v);
    int n = 0;
    if (v.ws0 != use0) begin
      hsel = 0;
      htrans = 0;
      repeat (4) @(posedge hclk);
      #1 use0 = v.ws0;
    end
    hsel = 1; htrans = 2'b10; hwrite = v.wr; haddr = v.a; hsize = v.sz;
    sb.push_back('{err: v.err, rd: (v.wr || v.err) ? 32'd0 : v.rd, cyc: v.err ? 2 : (v.ws0 ? 1 : 2)});
    @(negedge hclk);
    while (!hready && n < 40) begin
      n++;
      @(negedge hclk);
    end
    if (!hready) chk("accept timeout", 0, 1);
    @(posedge hclk);
    #1 hwdata = v.wd;
    hsel = 0;
    htrans = 0;
  endtask
  task automatic idle_cycles(input int n);
    hsel = 0;
    htrans = 0;
    repeat (n) @(posedge hclk);
    #1;
  endtask
  initial begin
    tv.push_back('{0, 1, 16'h2010, 3'd2, 32'hDEADBEEF, 0, 32'h0});
    tv.push_back('{0, 0, 16'h2010, 3'd2, 32'h0, 0, 32'hDEADBEEF});
    tv.push_back('{0, 1, 16'h2000, 3'd2, 32'h01020304, 0, 32'h0});
    tv.push_back('{0, 1, 16'h2020, 3'd2, 32'h00000000, 0, 32'h0});
    tv.push_back('{0, 1, 16'h2021, 3'd0, 32'hEEEE11EE, 0, 32'h0});
    tv.push_back('{0, 1, 16'h2022, 3'd1, 32'hAABBCCDD, 0, 32'h0});
    tv.push_back('{0, 0, 16'h2020, 3'd2, 32'h0, 0, 32'hAABB1100});
    tv.push_back('{0, 0, 16'h2002, 3'd2, 32'h0, 1, 32'h0});
    tv.push_back('{0, 0, 16'h2400, 3'd2, 32'h0, 1, 32'h0});
    tv.push_back('{0, 1, 16'h2400, 3'd2, 32'hFFFFFFFF, 1, 32'h0});
    tv.push_back('{0, 1, 16'h2012, 3'd2, 32'hFFFFFFFF, 1, 32'h0});
    tv.push_back('{0, 1, 16'h2021, 3'd1, 32'hFFFFFFFF, 1, 32'h0});
    tv.push_back('{0, 1, 16'h2020, 3'd3, 32'hFFFFFFFF, 1, 32'h0});
    tv.push_back('{0, 0, 16'h2010, 3'd2, 32'h0, 0, 32'hDEADBEEF});
    tv.push_back('{0, 0, 16'h2000, 3'd2, 32'h0, 0, 32'h01020304});
    tv.push_back('{0, 0, 16'h2022, 3'd1, 32'h0, 0, 32'hAABB1100});
    tv.push_back('{0, 1, 16'h2023, 3'd0, 32'h55667788, 0, 32'h0});
    tv.push_back('{0, 0, 16'h2020, 3'd2, 32'h0, 0, 32'h55BB1100});
    tv.push_back('{0, 1, 16'h2008, 3'd2, 32'hCAFEF00D, 0, 32'h0});
    tv.push_back('{0, 0, 16'h2008, 3'd2, 32'h0, 0, 32'hCAFEF00D});
    tv.push_back('{1, 1, 16'h2004, 3'd2, 32'h12345678, 0, 32'h0});
    tv.push_back('{1, 0, 16'h2004, 3'd2, 32'h0, 0, 32'h12345678});
    tv.push_back('{1, 0, 16'h2002, 3'd2, 32'h0, 1, 32'h0});
    tv.push_back('{1, 1, 16'h2000, 3'd2, 32'h00000000, 0, 32'h0});
    tv.push_back('{1, 1, 16'h2000, 3'd0, 32'h777777AB, 0, 32'h0});
    tv.push_back('{1, 0, 16'h2000, 3'd2, 32'h0, 0, 32'h000000AB});
    tv.push_back('{1, 1, 16'h23FC, 3'd2, 32'h0F0F0F0F, 0, 32'h0});
    tv.push_back('{1, 0, 16'h23FC, 3'd2, 32'h0, 0, 32'h0F0F0F0F});
    tv.push_back('{1, 0, 16'h2400, 3'd2, 32'h0, 1, 32'h0});
    repeat (3) @(posedge hclk);
    #1 rst = 0;
    foreach (tv[i]) issue(tv[i]);
    idle_cycles(4);
    use0 = 0;
    idle_cycles(2);
    hsel = 1; htrans = 2'b10; hwrite = 1; haddr = 16'h2008; hsize = 3'd2;
    @(posedge hclk);
    #1 hsel = 0;
    htrans = 0;
    hwdata = 32'h11111111;
    rst = 1;
    @(negedge hclk);
    chk("wait before rst", ro1, 0);
    @(posedge hclk);
    #1 rst = 0;
    @(negedge hclk);
    chk("post-rst hreadyout", ro1, 1);
    chk("post-rst hresp", rs1, 0);
    @(posedge hclk);
    #1 issue('{0, 0, 16'h2008, 3'd2, 32'h0, 0, 32'hCAFEF00D});
    idle_cycles(3);
    hsel = 1; hwrite = 1; haddr = 16'h2010; hsize = 3'd2; htrans = 2'b01;
    hwdata = 32'h99999999;
    repeat (2) @(posedge hclk);
    #1 htrans = 2'b00;
    repeat (2) @(posedge hclk);
    #1 hsel = 0;
    htrans = 2'b10;
    repeat (2) @(posedge hclk);
    #1 issue('{0, 0, 16'h2010, 3'd2, 32'h0, 0, 32'hDEADBEEF});
    idle_cycles(4);
    chk("scoreboard empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 Parameter WAIT_STATES, default 1: number of hreadyout-low cycles inserted per OKAY data phase (0..15).
REQ-002 Parameter MEM_WORDS, default 256: number of 32-bit words of storage; word index = haddr[9:2].
REQ-003 hclk  input  1  bus clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset rst, synchronous, active-high.
REQ-005 hsel  input  1  slave select from the address decoder.
REQ-006 haddr  input  16  byte address; only haddr[12:0] decoded locally.
REQ-007 htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 hwrite  input  1  1 = write, 0 = read.
REQ-009 hsize  input  3  0 byte, 1 halfword, 2 word; others illegal.
REQ-010 hwdata  input  32  write data, valid in data phase.
REQ-011 hready  input  1  bus-level ready (previous transfer complete).
REQ-012 hrdata  output  32  read data.
REQ-013 hreadyout  output  1  this slave's ready.
REQ-014 hresp  output  1  0 OKAY, 1 ERROR.

Function
REQ-015 Address phase SHALL be accepted on a rising edge with hsel=1, hready=1, htrans[1]=1; haddr, hwrite, hsize registered then.
REQ-016 IDLE/BUSY or hsel=0 with hready=1 SHALL produce no transfer and an OKAY zero-wait response.
REQ-017 Accepted transfer SHALL be flagged ERROR if: hsize>2; halfword with haddr[0]=1; word with haddr[1:0]!=0; haddr[12:2] >= MEM_WORDS.
REQ-018 State machine SHALL have states IDLE, WAIT, ERR1, ERR2.
REQ-019 IDLE: hreadyout=1, hresp=0; on accepted OKAY transfer -> WAIT if WAIT_STATES>0 (counter loaded WAIT_STATES-1) else stays IDLE with data phase completing next cycle; on accepted error transfer -> ERR1.
REQ-020 WAIT: hreadyout=0, hresp=0; counter decrements each cycle; at 0 -> IDLE, with the following cycle being the completing cycle (hreadyout=1).
REQ-021 ERR1: hreadyout=0, hresp=1, exactly one cycle -> ERR2.
REQ-022 ERR2: hreadyout=1, hresp=1, one cycle; a new address phase SHALL be accepted here as in IDLE.
REQ-023 OKAY data phase total length SHALL be WAIT_STATES+1 cycles; ERROR data phase exactly 2 cycles regardless of WAIT_STATES.
REQ-024 Write SHALL commit only on the completing cycle (hreadyout=1, hresp=0), using hwdata sampled that cycle.
REQ-025 Byte lanes written: byte -> lane haddr[1:0]; halfword -> lanes {haddr[1],0} and {haddr[1],1}; word -> all four; other lanes unchanged.
REQ-026 Read SHALL drive the full stored word on hrdata in the completing cycle; hrdata SHALL be 0 in all other cycles.
REQ-027 A read whose data phase follows a write's completing cycle to the same word SHALL return the newly written data (back-to-back, WAIT_STATES=0 included).
REQ-028 Errored writes SHALL not modify storage; errored reads SHALL drive hrdata=0.
REQ-029 Pipelined transfers SHALL be sustained: address phase of transfer N+1 accepted in completing cycle of N, giving one transfer per cycle when WAIT_STATES=0.

Reset
REQ-030 With rst=1 at a rising edge: state -> IDLE, counter -> 0, pending transfer discarded (no write commits), hreadyout=1, hresp=0, hrdata=0 from the next cycle.
REQ-031 Storage contents SHALL not be cleared by rst.
REQ-032 rst SHALL take priority over every other input, including mid-WAIT and ERR1.

Verification
REQ-033 WAIT_STATES=1: word write 0xDEADBEEF to 0x2010, then read 0x2010 -> write data phase 2 cycles (hreadyout 0,1), read returns 0xDEADBEEF on its second data-phase cycle, hresp=0.
REQ-034 Byte writes 0x11 to 0x2021, halfword 0xAABB to 0x2022 over word 0x00000000 -> word read of 0x2020 returns 0xAABB1100.
REQ-035 Word read at 0x2002 (misaligned) and at 0x2400 (out of range) -> each: hreadyout 0/hresp 1, then hreadyout 1/hresp 1, hrdata=0, no storage change.
REQ-036 WAIT_STATES=0: NONSEQ write 0x12345678 to 0x2004 immediately followed by read of 0x2004 -> hreadyout never low, read returns 0x12345678.
REQ-037 rst asserted in WAIT cycle of a write to 0x2008 (prior value 0xCAFEF00D) -> next cycle hreadyout=1, hresp=0; later read of 0x2008 returns 0xCAFEF00D.
REQ-038 hsel=1 with htrans=BUSY and with htrans=IDLE, and hsel=0 with NONSEQ -> hreadyout stays 1, hresp=0, no storage change.
